// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding and oversampling points.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned TICK_W     = 6;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver: start/DATA/stop framing, LSB first, no parity.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done,
  output logic            frame_error
);

  localparam int unsigned N_W = $clog2(DBIT);
  localparam logic [TICK_W-1:0] T_MID  = TICK_W'(MID_SAMPLE);
  localparam logic [TICK_W-1:0] T_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] T_STOP = TICK_W'(SB_TICK - 1);
  localparam logic [N_W-1:0]    N_LAST = N_W'(DBIT - 1);

  logic              rx_s;
  logic              rx_q;
  uart_state_e       state, state_next;
  logic [TICK_W-1:0] t, t_next;
  logic [N_W-1:0]    n, n_next;
  logic [DBIT-1:0]   sr, sr_next;
  logic [DBIT-1:0]   rx_data_next;
  logic              rx_done_next;
  logic              frame_error_next;

  sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_q        <= 1'b1;
      state       <= IDLE;
      t           <= '0;
      n           <= '0;
      sr          <= '0;
      rx_data     <= '0;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_q        <= rx_s;
      state       <= state_next;
      t           <= t_next;
      n           <= n_next;
      sr          <= sr_next;
      rx_data     <= rx_data_next;
      rx_done     <= rx_done_next;
      frame_error <= frame_error_next;
    end
  end

  // Next-state logic; only the IDLE edge detector runs without a tick.
  always_comb begin
    state_next       = state;
    t_next           = t;
    n_next           = n;
    sr_next          = sr;
    rx_data_next     = rx_data;
    rx_done_next     = 1'b0;
    frame_error_next = frame_error;
    case (state)
      IDLE: begin
        if (rx_q && !rx_s) begin
          state_next = START;
          t_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (t == T_MID) begin
            if (!rx_s) begin
              state_next = DATA;
              t_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            t_next = t + TICK_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (t == T_LAST) begin
            sr_next = {rx_s, sr[DBIT-1:1]};
            t_next  = '0;
            if (n == N_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n + N_W'(1);
            end
          end else begin
            t_next = t + TICK_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (t == T_STOP) begin
            rx_data_next     = sr;
            frame_error_next = ~rx_s;
            rx_done_next     = 1'b1;
            state_next       = IDLE;
          end else begin
            t_next = t + TICK_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: default instance with s_tick every 4 clk, plus a DBIT=7/2-stop instance with s_tick held high.
module tb_uart_receiver;

  localparam int LAT0 = 8 + 16 * 8 + 16;
  localparam int LAT7 = 8 + 16 * 7 + 32;

  typedef struct {
    logic [8:0] data;
    logic       fe;
    int         start_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx7 = 1'b1;
  logic       s_tick = 1'b0;
  logic       tick7 = 1'b1;
  logic [1:0] div = 2'd0;
  logic [7:0] rx_data0;
  logic       done0, fe0;
  logic [6:0] rx_data7;
  logic       done7, fe7;

  int   cyc = 0;
  int   tickcnt = 0;
  int   hist0[int];
  exp_t q0[$];
  exp_t q7[$];
  int   checks = 0;
  int   failures = 0;
  logic done0_prev = 1'b0;
  logic done7_prev = 1'b0;

  uart_receiver dut0 (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_tick      (s_tick),
    .rx          (rx),
    .rx_data     (rx_data0),
    .rx_done     (done0),
    .frame_error (fe0)
  );

  uart_receiver #(.DBIT(7), .SB_TICK(32)) dut7 (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_tick      (tick7),
    .rx          (rx7),
    .rx_data     (rx_data7),
    .rx_done     (done7),
    .frame_error (fe7)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div     <= div + 2'd1;
    s_tick  <= (div == 2'd3);
    cyc     <= cyc + 1;
    tickcnt <= tickcnt + (s_tick ? 1 : 0);
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever either receiver strobes rx_done.
  always @(negedge clk) begin
    exp_t e;
    hist0[cyc] = tickcnt;
    if (done0_prev) chk("done0_one_cycle", int'(done0), 0);
    if (done0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done0 actual=1 expected=0 data=%0h", rx_data0);
      end else begin
        e = q0.pop_front();
        chk("data0", int'(rx_data0), int'(e.data));
        chk("frame_error0", int'(fe0), int'(e.fe));
        chk("latency0", tickcnt - hist0[e.start_cyc], LAT0);
      end
    end
    done0_prev = done0;
    if (done7_prev) chk("done7_one_cycle", int'(done7), 0);
    if (done7 === 1'b1) begin
      if (q7.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done7 actual=1 expected=0 data=%0h", rx_data7);
      end else begin
        e = q7.pop_front();
        chk("data7", int'(rx_data7), int'(e.data));
        chk("frame_error7", int'(fe7), int'(e.fe));
        chk("latency7", cyc - e.start_cyc, LAT7);
      end
    end
    done7_prev = done7;
  end

  task automatic drive_line(input int sel, input logic v);
    if (sel == 0) rx = v;
    else rx7 = v;
  endtask

  // Waits n ticks of the selected receiver, returning just after the last tick edge.
  task automatic wait_ticks(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) begin
        do @(posedge clk); while (s_tick !== 1'b1);
      end else begin
        @(posedge clk);
      end
    end
    #1;
  endtask

  task automatic push_exp(input int sel, input logic [8:0] data, input logic fe);
    exp_t e;
    e.data      = data;
    e.fe        = fe;
    e.start_cyc = cyc + 3;
    if (sel == 0) q0.push_back(e);
    else q7.push_back(e);
  endtask

  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input logic stop, input int stop_ticks, input int gap);
    if (gap > 0) begin
      drive_line(sel, 1'b1);
      wait_ticks(sel, gap);
    end
    drive_line(sel, 1'b0);
    push_exp(sel, data, ~stop);
    wait_ticks(sel, 16);
    for (int i = 0; i < nbits; i++) begin
      drive_line(sel, data[i]);
      wait_ticks(sel, 16);
    end
    drive_line(sel, stop);
    wait_ticks(sel, stop_ticks);
    drive_line(sel, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] partial;
    logic [8:0] rdata;
    logic       rstop;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_data0", int'(rx_data0), 0);
    chk("reset_done0", int'(done0), 0);
    chk("reset_fe0", int'(fe0), 0);
    chk("reset_data7", int'(rx_data7), 0);
    reset_n = 1'b1;
    wait_ticks(0, 4);

    send_frame(0, 9'h55, 8, 1'b1, 16, 2);

    // Short low pulse must be rejected as a glitch.
    drive_line(0, 1'b0);
    wait_ticks(0, 3);
    drive_line(0, 1'b1);
    wait_ticks(0, 30);
    send_frame(0, 9'hC3, 8, 1'b1, 16, 0);

    send_frame(0, 9'hA3, 8, 1'b0, 16, 2);
    send_frame(0, 9'h0F, 8, 1'b1, 16, 1);

    send_frame(0, 9'h00, 8, 1'b1, 16, 4);
    send_frame(0, 9'hFF, 8, 1'b1, 16, 0);
    // Break: the falling edge yields one all-zero frame with a bad stop, then silence.
    drive_line(0, 1'b0);
    push_exp(0, 9'h00, 1'b1);
    wait_ticks(0, 600);
    drive_line(0, 1'b1);

    send_frame(0, 9'h96, 8, 1'b0, 16, 4);

    // Reset asserted during data bit 4 of 0xE5; the line is low at release.
    partial = 8'hE5;
    drive_line(0, 1'b1);
    wait_ticks(0, 2);
    drive_line(0, 1'b0);
    wait_ticks(0, 16);
    for (int i = 0; i < 4; i++) begin
      drive_line(0, partial[i]);
      wait_ticks(0, 16);
    end
    drive_line(0, partial[4]);
    wait_ticks(0, 8);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_data0", int'(rx_data0), 0);
    chk("midreset_done0", int'(done0), 0);
    chk("midreset_fe0", int'(fe0), 0);
    reset_n = 1'b1;
    wait_ticks(0, 3);
    drive_line(0, 1'b1);
    wait_ticks(0, 40);
    send_frame(0, 9'h3C, 8, 1'b1, 16, 0);

    for (int i = 0; i < 6; i++) begin
      rdata = 9'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      send_frame(0, rdata, 8, rstop, 16, int'($urandom_range(1, 20)));
    end

    send_frame(1, 9'h5A, 7, 1'b1, 32, 4);

    wait_ticks(0, 20);
    chk("pending0", q0.size(), 0);
    chk("pending7", q7.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
